// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control-unit inputs, instruction-memory port and IF/ID outputs.
// The master side is the fetch stage; the slave side is its surroundings.
interface fetch_stage_if;
    logic        stall_en;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] fetch_cnt;

    modport master (
        input  stall_en, pcsource, bpc, jpc, imem_rdata,
        output imem_addr, id_inst, id_pc4, id_valid, trap, trap_pc, fetch_cnt
    );

    modport slave (
        output stall_en, pcsource, bpc, jpc, imem_rdata,
        input  imem_addr, id_inst, id_pc4, id_valid, trap, trap_pc, fetch_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, one bubble per taken redirect.
// Define FETCH_TRAP_EN to make pcsource=2'b11 trap and halt; otherwise it fetches sequentially.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INST = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_stage_if.master  bus
);

`ifdef FETCH_TRAP_EN
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
`endif

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] inst_r, inst_s;
    logic [31:0] pc4_id_r, pc4_id_s;
    logic        valid_r, valid_s;
    logic [31:0] cnt_r, cnt_s;
    logic [31:0] pc4_s;
`ifdef FETCH_TRAP_EN
    logic        trap_r, trap_s;
    logic [31:0] trap_pc_r, trap_pc_s;
`endif

    assign pc4_s = pc_r + 32'd4;

    // Next-state and next-register selection; pcsource/stall_en only take effect at the edge.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        inst_s   = inst_r;
        pc4_id_s = pc4_id_r;
        valid_s  = valid_r;
        cnt_s    = cnt_r;
`ifdef FETCH_TRAP_EN
        trap_s    = trap_r;
        trap_pc_s = trap_pc_r;
`endif
        case (state_r)
            ST_BOOT: begin
                state_s = ST_RUN;
            end
            ST_RUN: begin
`ifdef FETCH_TRAP_EN
                if (bus.pcsource == 2'b11) begin
                    trap_s    = 1'b1;
                    trap_pc_s = pc_r;
                    inst_s    = BUBBLE_INST;
                    pc4_id_s  = 32'h0000_0000;
                    valid_s   = 1'b0;
                    state_s   = ST_HALT;
                end else
`endif
                if (bus.stall_en) begin
                    // Branch operands are stale while stalled, so stall outranks redirect.
                    state_s = ST_RUN;
                end else begin
                    case (bus.pcsource)
                        2'b01: begin
                            pc_s     = bus.bpc;
                            inst_s   = BUBBLE_INST;
                            pc4_id_s = 32'h0000_0000;
                            valid_s  = 1'b0;
                        end
                        2'b10: begin
                            pc_s     = bus.jpc;
                            inst_s   = BUBBLE_INST;
                            pc4_id_s = 32'h0000_0000;
                            valid_s  = 1'b0;
                        end
                        default: begin
                            pc_s     = pc4_s;
                            inst_s   = bus.imem_rdata;
                            pc4_id_s = pc4_s;
                            valid_s  = 1'b1;
                            cnt_s    = cnt_r + 32'd1;
                        end
                    endcase
                end
            end
`ifdef FETCH_TRAP_EN
            ST_HALT: begin
                valid_s = 1'b0;
            end
`endif
            default: begin
                state_s  = ST_BOOT;
                inst_s   = BUBBLE_INST;
                pc4_id_s = 32'h0000_0000;
                valid_s  = 1'b0;
            end
        endcase
    end

    // State, PC and IF/ID registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_BOOT;
            pc_r     <= RESET_PC;
            inst_r   <= BUBBLE_INST;
            pc4_id_r <= 32'h0000_0000;
            valid_r  <= 1'b0;
            cnt_r    <= 32'h0000_0000;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            inst_r   <= inst_s;
            pc4_id_r <= pc4_id_s;
            valid_r  <= valid_s;
            cnt_r    <= cnt_s;
        end
    end

`ifdef FETCH_TRAP_EN
    // Sticky trap flag and the PC at which it was taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_r    <= 1'b0;
            trap_pc_r <= 32'h0000_0000;
        end else begin
            trap_r    <= trap_s;
            trap_pc_r <= trap_pc_s;
        end
    end

    assign bus.trap    = trap_r;
    assign bus.trap_pc = trap_pc_r;
`else
    assign bus.trap    = 1'b0;
    assign bus.trap_pc = 32'h0000_0000;
`endif

    assign bus.imem_addr = pc_r;
    assign bus.id_inst   = inst_r;
    assign bus.id_pc4    = pc4_id_r;
    assign bus.id_valid  = valid_r;
    assign bus.fetch_cnt = cnt_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk plus randomized control against a rule-level model.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] BUB = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic [31:0] m_pc, m_inst, m_pc4, m_cnt, m_trap_pc;
    logic        m_valid, m_trap;
    bit          m_boot, m_halt;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RPC), .BUBBLE_INST(BUB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_rdata = bus.imem_addr ^ KEY;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = RPC; m_inst = BUB; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
        m_trap = 1'b0; m_trap_pc = 32'h0; m_boot = 1'b1; m_halt = 1'b0;
    endtask

    task automatic model_bubble();
        m_inst = BUB; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    // One clock edge of the fetch rules, first matching rule wins.
    task automatic model_step(input logic stall, input logic [1:0] src,
                              input logic [31:0] b, input logic [31:0] j);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            m_valid = 1'b0;
        end else if (TRAP_EN && src == 2'd3) begin
            m_trap = 1'b1; m_trap_pc = m_pc; model_bubble(); m_halt = 1'b1;
        end else if (stall) begin
            m_halt = 1'b0;
        end else if (src == 2'd1 || src == 2'd2) begin
            m_pc = (src == 2'd1) ? b : j;
            model_bubble();
        end else begin
            m_inst  = m_pc ^ KEY;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic check_all();
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("id_inst",   bus.id_inst,   m_inst);
        chk("id_pc4",    bus.id_pc4,    m_pc4);
        chk("id_valid",  {31'd0, bus.id_valid}, {31'd0, m_valid});
        chk("fetch_cnt", bus.fetch_cnt, m_cnt);
        chk("trap",      {31'd0, bus.trap}, {31'd0, m_trap});
        chk("trap_pc",   bus.trap_pc,   m_trap_pc);
    endtask

    task automatic step(input logic stall, input logic [1:0] src,
                        input logic [31:0] b, input logic [31:0] j);
        logic [31:0] pc_before;
        pc_before    = m_pc;
        bus.stall_en = stall;
        bus.pcsource = src;
        bus.bpc      = b;
        bus.jpc      = j;
        #1;
        chk("addr_before_edge", bus.imem_addr, pc_before);
        model_step(stall, src, b, j);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic       r_stall;
        logic [1:0] r_src;
        bus.stall_en = 1'b0; bus.pcsource = 2'b00; bus.bpc = 32'h0; bus.jpc = 32'h0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b0, 2'b00, 32'h0, 32'h0);
        chk("boot_no_load", {31'd0, bus.id_valid}, 32'd0);
        repeat (4) step(1'b0, 2'b00, 32'h0, 32'h0);
        chk("seq_fourth_inst", bus.id_inst, 32'hA5A5_010C);
        chk("seq_fourth_pc4", bus.id_pc4, 32'h0000_0110);
        chk("seq_cnt", bus.fetch_cnt, 32'd4);

        step(1'b0, 2'b01, 32'h0000_0108, 32'h0);
        repeat (3) step(1'b1, 2'b00, 32'h0, 32'h0);
        chk("stall_addr", bus.imem_addr, 32'h0000_0108);
        step(1'b0, 2'b00, 32'h0, 32'h0);
        chk("resume_inst", bus.id_inst, 32'hA5A5_0108);

        step(1'b0, 2'b01, 32'h0000_0400, 32'h0);
        chk("redir_bubble", {31'd0, bus.id_valid}, 32'd0);
        chk("redir_addr", bus.imem_addr, 32'h0000_0400);
        step(1'b0, 2'b00, 32'h0, 32'h0);
        chk("target_inst", bus.id_inst, 32'hA5A5_0400);
        chk("target_pc4", bus.id_pc4, 32'h0000_0404);

        step(1'b1, 2'b10, 32'h0, 32'h0000_0800);
        chk("stall_beats_jump", bus.imem_addr, 32'h0000_0404);
        step(1'b0, 2'b10, 32'h0, 32'h0000_0800);
        chk("jump_addr", bus.imem_addr, 32'h0000_0800);

        step(1'b0, 2'b10, 32'h0, 32'hFFFF_FFFC);
        step(1'b0, 2'b00, 32'h0, 32'h0);
        chk("wrap_addr", bus.imem_addr, 32'h0000_0000);
        chk("wrap_pc4", bus.id_pc4, 32'h0000_0000);
        chk("wrap_inst", bus.id_inst, 32'h5A5A_FFFC);

        step(1'b0, 2'b01, 32'h0000_0123, 32'h0);
        step(1'b0, 2'b00, 32'h0, 32'h0);
        chk("unaligned_pc4", bus.id_pc4, 32'h0000_0127);

        for (int i = 0; i < 300; i++) begin
            r_stall = ($urandom_range(0, 3) == 0);
            r_src   = 2'($urandom_range(0, 3));
            if (TRAP_EN && r_src == 2'd3) r_src = 2'd0;
            step(r_stall, r_src, $urandom, $urandom);
        end

        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 2'b00, 32'h0, 32'h0);
        step(1'b0, 2'b01, 32'h0000_0200, 32'h0);
        step(1'b0, 2'b11, 32'h0, 32'h0);
        if (TRAP_EN) begin
            chk("trap_set", {31'd0, bus.trap}, 32'd1);
            chk("trap_pc_val", bus.trap_pc, 32'h0000_0200);
            for (int i = 0; i < 10; i++) begin
                step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            end
            chk("halt_addr", bus.imem_addr, 32'h0000_0200);
            #2;
            rst_n = 1'b0;
            #1;
            model_reset();
            check_all();
            @(negedge clk);
            rst_n = 1'b1;
            step(1'b0, 2'b00, 32'h0, 32'h0);
            step(1'b0, 2'b00, 32'h0, 32'h0);
            chk("post_trap_inst", bus.id_inst, 32'hA5A5_0100);
        end else begin
            chk("no_trap", {31'd0, bus.trap}, 32'd0);
            chk("illegal_as_seq", bus.id_inst, 32'hA5A5_0200);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
